// File: rtl/puf_challenge_sequencer_if.sv
// Sequencer-side view of the LFSR obfuscator and PUF core: LFSR load/step
// controls plus the 4-phase challenge request/acknowledge pair.
interface puf_challenge_sequencer_if;
    logic [7:0] lfsr_seed;
    logic       lfsr_load;
    logic       lfsr_step;
    logic [7:0] lfsr_challenge;
    logic [7:0] puf_challenge;
    logic       puf_req;
    logic       puf_ack;
    logic       puf_resp;

    modport master (
        output lfsr_seed, lfsr_load, lfsr_step, puf_challenge, puf_req,
        input  lfsr_challenge, puf_ack, puf_resp
    );

    modport slave (
        input  lfsr_seed, lfsr_load, lfsr_step, puf_challenge, puf_req,
        output lfsr_challenge, puf_ack, puf_resp
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Seeds the LFSR, walks it through NUM_CHALLENGES challenges over a 4-phase
// req/ack handshake with the PUF core and packs the response bits.
module puf_challenge_sequencer #(
    parameter int NUM_CHALLENGES = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                seed,
    puf_challenge_sequencer_if.master bus,
    output logic [NUM_CHALLENGES-1:0] response_word,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
);
    localparam int IW = (NUM_CHALLENGES > 1) ? $clog2(NUM_CHALLENGES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHALLENGES - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, LATCH, REQ, RELEASE, STEP, DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx, idx_nxt;
    logic [TW-1:0]             tick, tick_nxt;
    logic [7:0]                seed_nxt, chal_nxt;
    logic [NUM_CHALLENGES-1:0] resp_nxt;
    logic                      terr_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            idx               <= '0;
            tick              <= '0;
            bus.lfsr_seed     <= '0;
            bus.lfsr_load     <= 1'b0;
            bus.lfsr_step     <= 1'b0;
            bus.puf_challenge <= '0;
            bus.puf_req       <= 1'b0;
            response_word     <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            state             <= state_nxt;
            idx               <= idx_nxt;
            tick              <= tick_nxt;
            bus.lfsr_seed     <= seed_nxt;
            bus.puf_challenge <= chal_nxt;
            response_word     <= resp_nxt;
            timeout_err       <= terr_nxt;
            // Strobes and status are decoded from the next state so they line
            // up with the state they belong to while still being flops.
            bus.lfsr_load     <= (state_nxt == LOAD);
            bus.lfsr_step     <= (state_nxt == STEP);
            bus.puf_req       <= (state_nxt == REQ);
            busy              <= (state_nxt != IDLE);
            done              <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        seed_nxt  = bus.lfsr_seed;
        chal_nxt  = bus.puf_challenge;
        resp_nxt  = response_word;
        terr_nxt  = timeout_err;
        tick_nxt  = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    seed_nxt  = seed;
                    resp_nxt  = '0;
                    idx_nxt   = '0;
                    terr_nxt  = 1'b0;
                    state_nxt = LOAD;
                end
            end
            LOAD:  state_nxt = LATCH;
            LATCH: begin
                chal_nxt  = bus.lfsr_challenge;
                state_nxt = REQ;
            end
            REQ: begin
                // A level-high ack on the first REQ cycle is taken as-is.
                if (bus.puf_ack) begin
                    for (int k = 0; k < NUM_CHALLENGES; k++)
                        if (idx == IW'(k)) resp_nxt[k] = bus.puf_resp;
                    state_nxt = RELEASE;
                end else if (tick == LAST_TICK) begin
                    terr_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            RELEASE: begin
                if (!bus.puf_ack) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + IW'(1);
                        state_nxt = STEP;
                    end
                end else if (tick == LAST_TICK) begin
                    terr_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            STEP:    state_nxt = LATCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Timeout restarts on entry to each wait state, counts while staying.
        if ((state_nxt == REQ || state_nxt == RELEASE) && state_nxt == state)
            tick_nxt = tick + TW'(1);
    end
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: two sequencers (4 challenges and 1 challenge) driving an
// 8-bit LFSR model (x^8+x^4+x^3+x^2+1) and a scriptable PUF responder.
module tb_puf_challenge_sequencer;
    typedef struct { logic [7:0] chal; int gap; int hi; } chal_t;
    typedef struct { logic [15:0] word; logic terr; int loads; int steps; } run_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic       start [2];
    logic [7:0] seed [2];
    logic [15:0] resp_pat [2];
    int         mute_idx [2];
    int         stick_idx [2];
    logic       clr [2];

    chal_t exp_chal [2][$];
    run_t  exp_run  [2][$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic        done_w [2];
    logic        busy_w [2];
    logic        terr_w [2];
    logic        req_w [2];
    logic [7:0]  chal_w [2];
    logic [15:0] rw_w [2];
    logic [63:0] outs_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int g, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, g, act, exp);
        end
    endfunction

    function automatic void flag(string name, int g);
        vectors++;
        miscompares++;
        $display("FAIL %s[%0d]: event not expected or not reached", name, g);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int N = (g == 0) ? 4 : 1;
        puf_challenge_sequencer_if bus();
        logic [N-1:0] rw;
        logic busy, done, terr;
        logic [7:0] lfsr;
        int pidx;

        puf_challenge_sequencer #(.NUM_CHALLENGES(N), .TIMEOUT_CYCLES(64)) dut (
            .clk(clk), .reset(reset), .start(start[g]), .seed(seed[g]), .bus(bus),
            .response_word(rw), .busy(busy), .done(done), .timeout_err(terr)
        );

        assign done_w[g] = done;
        assign busy_w[g] = busy;
        assign terr_w[g] = terr;
        assign req_w[g]  = bus.puf_req;
        assign chal_w[g] = bus.puf_challenge;
        assign rw_w[g]   = 16'(rw);
        assign outs_w[g] = 64'({bus.lfsr_seed, bus.lfsr_load, bus.lfsr_step, bus.puf_challenge,
                                bus.puf_req, 16'(rw), busy, done, terr});

        always @(posedge clk or negedge reset)
            if (!reset) lfsr <= 8'h00;
            else if (bus.lfsr_load) lfsr <= bus.lfsr_seed;
            else if (bus.lfsr_step) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[3] ^ lfsr[2] ^ lfsr[1]};
        assign bus.lfsr_challenge = lfsr;

        // Ack follows req by one cycle unless this challenge is muted/stuck.
        always @(posedge clk or negedge reset)
            if (!reset || clr[g]) begin
                bus.puf_ack <= 1'b0; bus.puf_resp <= 1'b0; pidx <= 0;
            end else if (bus.puf_req && !bus.puf_ack) begin
                if (pidx != mute_idx[g]) begin
                    bus.puf_ack <= 1'b1; bus.puf_resp <= resp_pat[g][pidx];
                end
            end else if (!bus.puf_req && bus.puf_ack && pidx != stick_idx[g]) begin
                bus.puf_ack <= 1'b0; bus.puf_resp <= 1'b0; pidx <= pidx + 1;
            end

        int mark, hi, hi_exp, nload, nstep;
        logic prev_req;
        chal_t ce;
        run_t re;
        always @(negedge clk) begin
            if (!reset) begin
                prev_req = 1'b0; nload = 0; nstep = 0; hi = 0; mark = cyc;
            end else begin
                if (start[g] && !busy) mark = cyc;
                if (bus.puf_req && !prev_req) begin
                    if (exp_chal[g].size() == 0) flag("unexpected_req", g);
                    else begin
                        ce = exp_chal[g].pop_front();
                        chk("challenge", g, bus.puf_challenge, ce.chal);
                        chk("req_latency", g, cyc - mark, ce.gap);
                        hi_exp = ce.hi;
                    end
                    mark = cyc; hi = 0;
                end
                if (bus.puf_req) hi++;
                if (!bus.puf_req && prev_req) chk("req_width", g, hi, hi_exp);
                prev_req = bus.puf_req;
                if (bus.lfsr_load) nload++;
                if (bus.lfsr_step) nstep++;
                if (done) begin
                    if (exp_run[g].size() == 0) flag("unexpected_done", g);
                    else begin
                        re = exp_run[g].pop_front();
                        chk("response_word", g, 16'(rw), re.word);
                        chk("timeout_err", g, terr, re.terr);
                        chk("load_pulses", g, nload, re.loads);
                        chk("step_pulses", g, nstep, re.steps);
                    end
                    nload = 0; nstep = 0;
                end
            end
        end
    end

    task automatic push_chal(int g, logic [7:0] c, int gap, int hi);
        exp_chal[g].push_back('{c, gap, hi});
    endtask

    task automatic push_run(int g, logic [15:0] w, logic t, int l, int s);
        exp_run[g].push_back('{w, t, l, s});
    endtask

    task automatic push_run_a();
        push_chal(0, 8'h01, 3, 2); push_chal(0, 8'h02, 6, 2);
        push_chal(0, 8'h05, 6, 2); push_chal(0, 8'h0B, 6, 2);
        push_run(0, 16'h000D, 1'b0, 1, 3);
    endtask

    task automatic run_start(int g, logic [7:0] s);
        seed[g] = s; start[g] = 1'b1;
        @(posedge clk); #1;
        start[g] = 1'b0;
    endtask

    task automatic wait_done(int g, int budget);
        int n = 0;
        while (!done_w[g] && n < budget) begin @(posedge clk); #1; n++; end
        if (!done_w[g]) flag("done_timeout", g);
    endtask

    task automatic clr_model(int g);
        clr[g] = 1'b1;
        @(posedge clk); #1;
        clr[g] = 1'b0; mute_idx[g] = -1; stick_idx[g] = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog[0]: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; seed[g] = 8'h00; resp_pat[g] = 16'h0;
            mute_idx[g] = -1; stick_idx[g] = -1; clr[g] = 1'b0;
        end
        #2 reset = 1'b0;
        #10;
        for (int g = 0; g < 2; g++) chk("reset_outputs", g, outs_w[g], 64'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // Nominal 4-challenge run.
        resp_pat[0] = 16'b1101;
        push_run_a();
        run_start(0, 8'h01);
        wait_done(0, 200);
        clr_model(0);

        // Single-challenge instance never steps.
        resp_pat[1] = 16'b1;
        push_chal(1, 8'hA5, 3, 2);
        push_run(1, 16'h0001, 1'b0, 1, 0);
        run_start(1, 8'hA5);
        wait_done(1, 100);
        clr_model(1);

        // Ack never arrives for challenge index 2.
        mute_idx[0] = 2;
        push_chal(0, 8'h01, 3, 2); push_chal(0, 8'h02, 6, 2); push_chal(0, 8'h05, 6, 64);
        push_run(0, 16'h0001, 1'b1, 1, 2);
        run_start(0, 8'h01);
        wait_done(0, 300);
        @(posedge clk); #1;
        chk("terr_held", 0, terr_w[0], 1'b1);
        chk("word_held", 0, rw_w[0], 16'h0001);
        chk("busy_idle", 0, busy_w[0], 1'b0);
        clr_model(0);

        // Ack stuck high after challenge index 1; its bit must survive.
        resp_pat[0] = 16'b0110; stick_idx[0] = 1;
        push_chal(0, 8'h01, 3, 2); push_chal(0, 8'h02, 6, 2);
        push_run(0, 16'h0002, 1'b1, 1, 1);
        run_start(0, 8'h01);
        chk("terr_cleared", 0, terr_w[0], 1'b0);
        chk("word_cleared", 0, rw_w[0], 16'h0000);
        wait_done(0, 300);
        clr_model(0);

        // start toggled while busy: exactly one load for the run.
        resp_pat[0] = 16'b1101;
        push_run_a();
        fork
            begin run_start(0, 8'h01); wait_done(0, 200); end
            begin
                repeat (4) @(posedge clk);
                repeat (10) begin @(posedge clk); #2 start[0] = ~start[0]; end
                start[0] = 1'b0;
            end
        join
        clr_model(0);

        // start held through DONE: a second run only after IDLE.
        push_run_a(); push_run_a();
        seed[0] = 8'h01; start[0] = 1'b1;
        wait_done(0, 200);
        clr_model(0);
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, 200);
        clr_model(0);

        // Reset while waiting on the index-3 request.
        push_chal(0, 8'h01, 3, 2); push_chal(0, 8'h02, 6, 2);
        push_chal(0, 8'h05, 6, 2); push_chal(0, 8'h0B, 6, 2);
        run_start(0, 8'h01);
        begin
            int n = 0;
            while (!(req_w[0] && chal_w[0] == 8'h0B) && n < 200) begin @(posedge clk); #1; n++; end
            if (!req_w[0]) flag("reach_req3", 0);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) chk("midrun_reset_outputs", g, outs_w[g], 64'h0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        push_run_a();
        run_start(0, 8'h01);
        wait_done(0, 200);
        repeat (3) @(posedge clk);
        #1;

        for (int g = 0; g < 2; g++) begin
            chk("chal_queue_left", g, exp_chal[g].size(), 0);
            chk("run_queue_left", g, exp_run[g].size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
